// File: rtl/pr_bridge_timer.sv
// Processor-bus I/O bridge: two countdown timers, a 32-bit input port, a 32-bit output register
// and the HWInt[7:2] interrupt lines into CP0.
module pr_bridge_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] PrAddr,
    input  logic [3:0]  PrBE,
    input  logic [31:0] PrWD,
    input  logic        PrWe,
    output logic [31:0] PrRD,
    output logic [7:2]  HWInt,
    input  logic [31:0] dev_in,
    output logic [31:0] dev_out,
    input  logic [3:0]  ext_irq
);

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 30;
    localparam int unsigned CTRL_W    = 4;
    localparam int unsigned NUM_TMR   = 2;
    localparam int unsigned WIN_WORDS = 10;
    localparam int unsigned IN_IDX    = 8;
    localparam int unsigned OUT_IDX   = 9;
    localparam logic [ADDR_W-1:0] BASE_WORD = BASE_ADDR[31:2];

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} timerState_e;

    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } timerCtrl_t;

    timerState_e             state     [NUM_TMR];
    timerState_e             stateNxt  [NUM_TMR];
    timerCtrl_t              ctrl      [NUM_TMR];
    timerCtrl_t              ctrlNxt   [NUM_TMR];
    logic [DATA_W-1:0]       preset    [NUM_TMR];
    logic [DATA_W-1:0]       presetNxt [NUM_TMR];
    logic [DATA_W-1:0]       count     [NUM_TMR];
    logic [DATA_W-1:0]       countNxt  [NUM_TMR];
    logic [NUM_TMR-1:0]      irqPend;
    logic [NUM_TMR-1:0]      irqPendNxt;
    logic [NUM_TMR-1:0]      irqSet;
    logic [DATA_W-1:0]       devOutNxt;

    logic [ADDR_W-1:0]       wordOff;
    logic                    inWin;
    logic [3:0]              regIdx;
    logic                    wrHit;

    // Window decode: full 30-bit compare via unsigned offset from the base word
    assign wordOff = PrAddr - BASE_WORD;
    assign inWin   = wordOff < ADDR_W'(WIN_WORDS);
    assign regIdx  = wordOff[3:0];
    assign wrHit   = PrWe && inWin;

    function automatic logic [DATA_W-1:0] mergeBytes(
        input logic [DATA_W-1:0] cur,
        input logic [DATA_W-1:0] wd,
        input logic [3:0]        be
    );
        logic [DATA_W-1:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = wd[8*b +: 8];
        end
        return res;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_TMR); i++) begin
                state[i]  <= IDLE;
                ctrl[i]   <= '0;
                preset[i] <= '0;
                count[i]  <= '0;
            end
            irqPend <= '0;
            dev_out <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_TMR); i++) begin
                state[i]  <= stateNxt[i];
                ctrl[i]   <= ctrlNxt[i];
                preset[i] <= presetNxt[i];
                count[i]  <= countNxt[i];
            end
            irqPend <= irqPendNxt;
            dev_out <= devOutNxt;
        end
    end

    // Timer FSMs and CPU stores; CPU CTRL value beats INT's EN clear, irq set beats CTRL-write clear
    always_comb begin
        stateNxt   = state;
        ctrlNxt    = ctrl;
        presetNxt  = preset;
        countNxt   = count;
        irqPendNxt = irqPend;
        irqSet     = '0;
        devOutNxt  = dev_out;

        for (int i = 0; i < int'(NUM_TMR); i++) begin
            case (state[i])
                IDLE: begin
                    if (ctrl[i].en) stateNxt[i] = LOAD;
                end
                LOAD: begin
                    countNxt[i] = preset[i];
                    stateNxt[i] = CNT;
                end
                CNT: begin
                    if (!ctrl[i].en) begin
                        stateNxt[i] = IDLE;
                    end else if (count[i] <= DATA_W'(1)) begin
                        countNxt[i] = '0;
                        irqSet[i]   = 1'b1;
                        stateNxt[i] = INT;
                    end else begin
                        countNxt[i] = count[i] - DATA_W'(1);
                    end
                end
                INT: begin
                    if (ctrl[i].mode == 2'b01) begin
                        irqPendNxt[i] = 1'b0;
                        stateNxt[i]   = LOAD;
                    end else begin
                        ctrlNxt[i].en = 1'b0;
                        stateNxt[i]   = IDLE;
                    end
                end
                default: stateNxt[i] = IDLE;
            endcase

            if (wrHit && regIdx == 4'(4*i)) begin
                irqPendNxt[i] = 1'b0;
                if (PrBE[0]) ctrlNxt[i] = timerCtrl_t'(PrWD[CTRL_W-1:0]);
            end
            if (wrHit && regIdx == 4'(4*i + 1)) begin
                presetNxt[i] = mergeBytes(preset[i], PrWD, PrBE);
            end
            if (irqSet[i]) irqPendNxt[i] = 1'b1;
        end

        if (wrHit && regIdx == 4'(OUT_IDX)) begin
            devOutNxt = mergeBytes(dev_out, PrWD, PrBE);
        end
    end

    // Combinational read mux; holes and out-of-window addresses read zero
    always_comb begin
        PrRD = '0;
        if (inWin) begin
            for (int i = 0; i < int'(NUM_TMR); i++) begin
                if (regIdx == 4'(4*i))     PrRD[CTRL_W-1:0] = ctrl[i];
                if (regIdx == 4'(4*i + 1)) PrRD = preset[i];
                if (regIdx == 4'(4*i + 2)) PrRD = count[i];
            end
            if (regIdx == 4'(IN_IDX))  PrRD = dev_in;
            if (regIdx == 4'(OUT_IDX)) PrRD = dev_out;
        end
    end

    assign HWInt = {ext_irq, irqPend[1] & ctrl[1].im, irqPend[0] & ctrl[0].im};

endmodule

// File: tb/tb_pr_bridge_timer.sv
// Directed + randomized bench for pr_bridge_timer against a cycle-level behavioural model.
module tb_pr_bridge_timer;

    localparam logic [29:0] BASE_W = 30'h1FC0;

    logic        clk;
    logic        reset;
    logic [29:0] PrAddr;
    logic [3:0]  PrBE;
    logic [31:0] PrWD;
    logic        PrWe;
    logic [31:0] PrRD;
    logic [7:2]  HWInt;
    logic [31:0] dev_in;
    logic [31:0] dev_out;
    logic [3:0]  ext_irq;

    int nTests = 0;
    int nFail  = 0;

    // Behavioural model state
    bit        mEn[2];
    bit [1:0]  mMode[2];
    bit        mIm[2];
    bit [31:0] mPreset[2];
    bit [31:0] mCount[2];
    bit        mIrq[2];
    bit        mLoadPend[2];
    bit        mCounting[2];
    bit        mExpired[2];
    bit [31:0] mOut;

    pr_bridge_timer dut (
        .clk(clk), .reset(reset), .PrAddr(PrAddr), .PrBE(PrBE), .PrWD(PrWD),
        .PrWe(PrWe), .PrRD(PrRD), .HWInt(HWInt), .dev_in(dev_in),
        .dev_out(dev_out), .ext_irq(ext_irq)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    initial begin
        #(100 * 20000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic bit [31:0] merge(input bit [31:0] cur, input bit [31:0] wd, input bit [3:0] be);
        bit [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic bit [31:0] mRead(input logic [29:0] a);
        bit [29:0] off;
        off = a - BASE_W;
        case (off)
            30'd0: return {28'b0, mIm[0], mMode[0], mEn[0]};
            30'd1: return mPreset[0];
            30'd2: return mCount[0];
            30'd4: return {28'b0, mIm[1], mMode[1], mEn[1]};
            30'd5: return mPreset[1];
            30'd6: return mCount[1];
            30'd8: return dev_in;
            30'd9: return mOut;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit [5:0] mHw();
        return {ext_irq, mIrq[1] & mIm[1], mIrq[0] & mIm[0]};
    endfunction

    // One rising edge of the model, using the inputs currently applied
    task automatic modelEdge();
        bit [29:0] off;
        bit        hit;
        bit        setIrq;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mEn[i] = 0; mMode[i] = 0; mIm[i] = 0; mPreset[i] = 0; mCount[i] = 0;
                mIrq[i] = 0; mLoadPend[i] = 0; mCounting[i] = 0; mExpired[i] = 0;
            end
            mOut = 0;
            return;
        end
        off = PrAddr - BASE_W;
        hit = PrWe && (off < 30'd10);
        for (int i = 0; i < 2; i++) begin
            setIrq = 0;
            if (mExpired[i]) begin
                mExpired[i] = 0;
                if (mMode[i] == 2'b01) begin
                    mIrq[i] = 0;
                    mLoadPend[i] = 1;
                end else begin
                    mEn[i] = 0;
                end
            end else if (mLoadPend[i]) begin
                mLoadPend[i] = 0;
                mCount[i] = mPreset[i];
                mCounting[i] = 1;
            end else if (mCounting[i]) begin
                if (!mEn[i]) mCounting[i] = 0;
                else if (mCount[i] <= 1) begin
                    mCount[i] = 0; setIrq = 1; mExpired[i] = 1; mCounting[i] = 0;
                end else mCount[i] = mCount[i] - 1;
            end else if (mEn[i]) begin
                mLoadPend[i] = 1;
            end
            if (hit && off == 30'(4*i)) begin
                mIrq[i] = 0;
                if (PrBE[0]) begin
                    mEn[i] = PrWD[0]; mMode[i] = PrWD[2:1]; mIm[i] = PrWD[3];
                end
            end
            if (hit && off == 30'(4*i + 1)) mPreset[i] = merge(mPreset[i], PrWD, PrBE);
            if (setIrq) mIrq[i] = 1;
        end
        if (hit && off == 30'd9) mOut = merge(mOut, PrWD, PrBE);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic checkAll(input string tag);
        #1;
        chk({tag, "_rd"}, PrRD, mRead(PrAddr));
        chk({tag, "_hw"}, 32'(HWInt), 32'(mHw()));
        chk({tag, "_out"}, dev_out, mOut);
    endtask

    task automatic rdChk(input string tag, input logic [29:0] addr, input logic [31:0] exp);
        PrAddr = addr;
        PrWe   = 1'b0;
        #1;
        chk(tag, PrRD, exp);
        chk({tag, "_m"}, PrRD, mRead(addr));
    endtask

    task automatic wr(input int off, input logic [31:0] d, input logic [3:0] be);
        PrAddr = BASE_W + 30'(off);
        PrWD   = d;
        PrBE   = be;
        PrWe   = 1'b1;
        step();
        PrWe   = 1'b0;
    endtask

    initial begin
        int pulses;
        int r;
        int off;
        reset = 1'b1; PrAddr = '0; PrBE = '0; PrWD = '0; PrWe = 1'b0;
        dev_in = '0; ext_irq = 4'b1010;
        step(); step();
        reset = 1'b0;

        // Reset values and decode holes
        for (int k = 0; k < 10; k++) rdChk($sformatf("rst_reg%0d", k), BASE_W + 30'(k), 32'h0);
        rdChk("rst_hole7F0C", 30'h1FC3, 32'h0);
        rdChk("rst_8000", 30'h2000, 32'h0);
        rdChk("rst_below", BASE_W - 30'd1, 32'h0);
        rdChk("rst_above", BASE_W + 30'd10, 32'h0);
        chk("rst_hwint", 32'(HWInt), 32'h28);
        chk("rst_devout", dev_out, 32'h0);

        // T0 one-shot, PRESET=5
        wr(1, 32'd5, 4'hF);
        wr(0, 32'h9, 4'hF);
        step(); step();
        rdChk("t0_cnt0", BASE_W + 30'd2, 32'd5);
        chk("t0_irq0", 32'(HWInt[2]), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            rdChk($sformatf("t0_cnt%0d", k), BASE_W + 30'd2, 32'(5 - k));
            chk($sformatf("t0_irq%0d", k), 32'(HWInt[2]), 32'(k == 5));
        end
        rdChk("t0_ctrl_int", BASE_W, 32'h9);
        step();
        rdChk("t0_ctrl_idle", BASE_W, 32'h8);
        chk("t0_irq_sticky", 32'(HWInt[2]), 32'd1);
        step(); step();
        checkAll("t0_hold");
        chk("t0_irq_held", 32'(HWInt[2]), 32'd1);
        wr(0, 32'h8, 4'hF);
        checkAll("t0_clr");
        chk("t0_irq_clr", 32'(HWInt[2]), 32'd0);

        // T1 auto-reload, PRESET=3 -> pulse every 5 cycles
        wr(5, 32'd3, 4'hF);
        wr(4, 32'hB, 4'hF);
        pulses = 0;
        for (int k = 1; k <= 22; k++) begin
            step();
            checkAll("t1_run");
            chk($sformatf("t1_pulse%0d", k), 32'(HWInt[3]), 32'((k % 5) == 0));
            pulses += int'(HWInt[3]);
        end
        chk("t1_npulses", 32'(pulses), 32'd4);
        wr(4, 32'h0, 4'hF);
        step(); step();
        checkAll("t1_off");

        // Byte enables, read-only registers, input port
        wr(9, 32'h0, 4'hF);
        wr(9, 32'hAABBCCDD, 4'b0100);
        chk("out_byte2", dev_out, 32'h00BB0000);
        rdChk("out_rd", BASE_W + 30'd9, 32'h00BB0000);
        wr(2, 32'h1234, 4'hF);
        rdChk("count_ro", BASE_W + 30'd2, 32'h0);
        dev_in = 32'hCAFE;
        rdChk("in_rd", BASE_W + 30'd8, 32'hCAFE);
        wr(8, 32'h5555, 4'hF);
        rdChk("in_ro", BASE_W + 30'd8, 32'hCAFE);

        // EN cleared mid-count freezes COUNT
        wr(1, 32'd100, 4'hF);
        wr(0, 32'h9, 4'hF);
        repeat (61) step();
        rdChk("frz_41", BASE_W + 30'd2, 32'd41);
        wr(0, 32'h8, 4'hF);
        for (int k = 0; k < 4; k++) begin
            step();
            rdChk($sformatf("frz_40_%0d", k), BASE_W + 30'd2, 32'd40);
            chk("frz_noirq", 32'(HWInt[2]), 32'd0);
        end

        // Masked expiry: irq pending internally, HWInt[2] stays low
        wr(1, 32'd3, 4'hF);
        wr(0, 32'h1, 4'hF);
        for (int k = 0; k < 8; k++) begin
            step();
            checkAll("msk_run");
            chk("msk_hw2", 32'(HWInt[2]), 32'd0);
        end
        rdChk("msk_cnt", BASE_W + 30'd2, 32'd0);
        wr(0, 32'h8, 4'hF);
        chk("msk_setim", 32'(HWInt[2]), 32'd0);

        // Same-edge collisions
        wr(1, 32'd2, 4'hF);
        wr(0, 32'h9, 4'hF);
        step(); step(); step();
        wr(0, 32'h9, 4'hF);
        rdChk("col_ctrl", BASE_W, 32'h9);
        chk("col_irq_set_wins", 32'(HWInt[2]), 32'd1);
        wr(0, 32'h9, 4'hF);
        rdChk("col_en_cpu_wins", BASE_W, 32'h9);
        checkAll("col_after");

        // Reset pulse while both timers count
        wr(5, 32'd50, 4'hF);
        wr(4, 32'hB, 4'hF);
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) rdChk($sformatf("mrst_reg%0d", k), BASE_W + 30'(k), (k == 8) ? dev_in : 32'h0);
        chk("mrst_hwint", 32'(HWInt), {26'b0, ext_irq, 2'b00});
        chk("mrst_devout", dev_out, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            ext_irq = 4'($urandom);
            dev_in  = $urandom;
            reset   = ($urandom_range(0, 149) == 0);
            r = $urandom_range(0, 9);
            PrBE = 4'($urandom);
            PrWD = $urandom;
            if (r < 4) begin
                off = $urandom_range(0, 11);
                if (off == 1 || off == 5) PrWD = $urandom_range(0, 6);
                if (off == 0 || off == 4) PrWD = $urandom_range(0, 15);
                PrAddr = BASE_W + 30'(off);
                PrWe = 1'b1;
            end else if (r == 4) begin
                PrAddr = 30'($urandom);
                PrWe = 1'($urandom);
            end else begin
                PrAddr = BASE_W + 30'($urandom_range(0, 11));
                PrWe = 1'b0;
            end
            checkAll("rnd");
            step();
            PrWe  = 1'b0;
            reset = 1'b0;
        end
        checkAll("rnd_end");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
